// File: rtl/jtcop_pkg.sv
// Shared definitions for the graphics ROM arbiter: requester ids, FSM states, pick helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package jtcop_pkg;

    localparam int NUM_REQ = 4;

    localparam logic [1:0] BA0_ID = 2'd0;
    localparam logic [1:0] BA1_ID = 2'd1;
    localparam logic [1:0] BA2_ID = 2'd2;
    localparam logic [1:0] OBJ_ID = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    // First pending index at or after rr, wrapping 3->0. Scanning from the
    // farthest offset down leaves the nearest pending index as the result.
    function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] rr);
        logic [1:0] idx;
        rr_pick = rr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = rr + 2'(k);
            if (pend[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/jtcop_gfx_arb_slot.sv
// One requester's single-entry result store: last fetched tag/data plus valid, ok/pend.
// Latency: ok is combinational on cs/addr; a load is visible the cycle after the strobe.
// Backpressure: none; pend stays high until a matching fetch lands.
//
// Ports: cs/addr from the requester; load/load_addr/load_data from the arbiter
// when a fetch for this requester completes; ok/pend/dat back out.
module jtcop_gfx_arb_slot #(
    parameter int AW = 17,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    output logic          ok,
    output logic          pend,
    output logic [DW-1:0] dat
);

    logic [AW-1:0] tag;
    logic          vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag <= '0;
            dat <= '0;
            vld <= 1'b0;
        end else if (load) begin
            tag <= load_addr;
            dat <= load_data;
            vld <= 1'b1;
        end
    end

    // An address change or a dropped cs kills ok in the same cycle.
    assign ok   = cs & vld & (addr == tag);
    assign pend = cs & ~ok;

endmodule

// File: rtl/jtcop_gfx_arb.sv
// Shares one SDRAM read port among the ba0/ba1/ba2/obj graphics ROM requesters.
// Latency: mem_cs one cycle after pend rises; req_ok the cycle after mem_ok; 2 clocks minimum per access.
// Backpressure: requests queue as pend levels; mem_cs/mem_addr held until mem_ok, never withdrawn.
//
// Ports: req_cs/req_addr in, req_data (one DW slice per requester)/req_ok out,
// mem_cs/mem_addr={id,addr} out to SDRAM, mem_data/mem_ok pulse back.
module jtcop_gfx_arb
    import jtcop_pkg::*;
#(
    parameter int AW       = 17,
    parameter int DW       = 32,
    parameter int OBJ_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req_cs,
    input  logic [4*AW-1:0]   req_addr,
    output logic [4*DW-1:0]   req_data,
    output logic [3:0]        req_ok,
    output logic              mem_cs,
    output logic [AW+1:0]     mem_addr,
    input  logic [DW-1:0]     mem_data,
    input  logic              mem_ok
);

    arb_state_t    state, state_nxt;
    logic [1:0]    rr, rr_nxt;
    logic [1:0]    cur, cur_nxt;
    logic [AW-1:0] cur_addr, cur_addr_nxt;
    logic          mem_cs_nxt;
    logic [AW+1:0] mem_addr_nxt;
    logic [1:0]    winner;

    logic [3:0]    pend;
    logic [3:0]    load;
    logic [AW-1:0] addr_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        assign addr_arr[i] = req_addr[i*AW +: AW];
        assign load[i]     = (state == WAIT) && mem_ok && (cur == 2'(i));

        jtcop_gfx_arb_slot #(
            .AW (AW),
            .DW (DW)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .cs        (req_cs[i]),
            .addr      (addr_arr[i]),
            .load      (load[i]),
            .load_addr (cur_addr),
            .load_data (mem_data),
            .ok        (req_ok[i]),
            .pend      (pend[i]),
            .dat       (req_data[i*DW +: DW])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr       <= 2'd0;
            cur      <= 2'd0;
            cur_addr <= '0;
            mem_cs   <= 1'b0;
            mem_addr <= '0;
        end else begin
            state    <= state_nxt;
            rr       <= rr_nxt;
            cur      <= cur_nxt;
            cur_addr <= cur_addr_nxt;
            mem_cs   <= mem_cs_nxt;
            mem_addr <= mem_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_nxt       = rr;
        cur_nxt      = cur;
        cur_addr_nxt = cur_addr;
        mem_cs_nxt   = mem_cs;
        mem_addr_nxt = mem_addr;
        winner       = ((OBJ_PRIO != 0) && pend[OBJ_ID]) ? OBJ_ID : rr_pick(pend, rr);

        case (state)
            IDLE: begin
                if (|pend) begin
                    mem_cs_nxt   = 1'b1;
                    mem_addr_nxt = {winner, addr_arr[winner]};
                    cur_nxt      = winner;
                    cur_addr_nxt = addr_arr[winner];
                    state_nxt    = WAIT;
                end
            end
            WAIT: begin
                // The in-flight address is committed; a requester that moved on
                // simply sees a tag mismatch afterwards and pends again.
                if (mem_ok) begin
                    mem_cs_nxt = 1'b0;
                    rr_nxt     = cur + 2'd1;
                    state_nxt  = IDLE;
                end
            end
        endcase
    end

endmodule
